// File: rtl/button_request_conditioner.sv
// Button front end: sync, debounce, sticky requests, auto-repeat, pause.
// Requests hold until the game core strobes step.
module button_request_conditioner #(
  parameter int unsigned DB_CYCLES  = 250000,
  parameter int unsigned RPT_DELAY  = 12500000,
  parameter int unsigned RPT_PERIOD = 5000000,
  parameter int unsigned CNT_W      = 25
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] btn_raw,
  input  logic       step,
  output logic       Left,
  output logic       Right,
  output logic       start,
  output logic       restart,
  output logic       pause,
  output logic [4:0] held
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST =
    CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST =
    CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [4:0]       sync1_q, sync1_d;
  logic [4:0]       sync2_q, sync2_d;
  logic [4:0]       held_q, held_d;
  logic [4:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dc_q [5];
  logic [CNT_W-1:0] dc_d [5];

  logic [1:0]       st_q [2];
  logic [1:0]       st_d [2];
  logic [CNT_W-1:0] rc_q [2];
  logic [CNT_W-1:0] rc_d [2];

  logic left_q, left_d;
  logic right_q, right_d;
  logic start_q, start_d;
  logic restart_q, restart_d;
  logic pause_q, pause_d;

  logic [4:0] press;
  logic [1:0] rep;
  logic       ev_l, ev_r;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = held_q;
  end

  // A level change is accepted only after a full run of mismatches.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < 5; i++) begin
      dc_d[i] = '0;
      if (sync2_q[i] != held_q[i]) begin
        if (dc_q[i] == DB_LAST) begin
          held_d[i] = ~held_q[i];
        end else begin
          dc_d[i] = dc_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign press = held_q & ~prev_q;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      st_d[d] = st_q[d];
      rc_d[d] = rc_q[d];
      rep[d]  = 1'b0;
      if (!held_q[d]) begin
        st_d[d] = S_IDLE;
        rc_d[d] = '0;
      end else begin
        case (st_q[d])
          S_IDLE: begin
            if (press[d]) begin
              st_d[d] = S_DELAY;
              rc_d[d] = '0;
            end
          end
          S_DELAY: begin
            if (rc_q[d] == RD_LAST) begin
              rep[d]  = 1'b1;
              st_d[d] = S_REPEAT;
              rc_d[d] = '0;
            end else begin
              rc_d[d] = rc_q[d] + CNT_ONE;
            end
          end
          S_REPEAT: begin
            if (rc_q[d] == RP_LAST) begin
              rep[d]  = 1'b1;
              rc_d[d] = '0;
            end else begin
              rc_d[d] = rc_q[d] + CNT_ONE;
            end
          end
          default: begin
            st_d[d] = S_IDLE;
            rc_d[d] = '0;
          end
        endcase
      end
    end
  end

  assign ev_l = press[0] | rep[0];
  assign ev_r = press[1] | rep[1];

  // New events beat step and restart; Left beats Right.
  always_comb begin
    left_d    = left_q;
    right_d   = right_q;
    start_d   = start_q;
    restart_d = restart_q;
    pause_d   = pause_q;

    if (ev_l) begin
      left_d = 1'b1;
    end else if (ev_r || press[3] || step) begin
      left_d = 1'b0;
    end

    if (ev_r && !ev_l) begin
      right_d = 1'b1;
    end else if (ev_l || press[3] || step) begin
      right_d = 1'b0;
    end

    if (press[2]) begin
      start_d = 1'b1;
    end else if (step) begin
      start_d = 1'b0;
    end

    if (press[3]) begin
      restart_d = 1'b1;
    end else if (step) begin
      restart_d = 1'b0;
    end

    if (press[3]) begin
      pause_d = 1'b0;
    end else if (press[4]) begin
      pause_d = ~pause_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      held_q  <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 5; i++) begin
        dc_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      prev_q  <= prev_d;
      for (int i = 0; i < 5; i++) begin
        dc_q[i] <= dc_d[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int d = 0; d < 2; d++) begin
        st_q[d] <= S_IDLE;
        rc_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        st_q[d] <= st_d[d];
        rc_q[d] <= rc_d[d];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      left_q    <= left_d;
      right_q   <= right_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      pause_q   <= pause_d;
    end
  end

  assign Left    = left_q;
  assign Right   = right_q;
  assign start   = start_q;
  assign restart = restart_q;
  assign pause   = pause_q;
  assign held    = held_q;

endmodule

// File: tb/tb_button_request_conditioner.sv
// Bench for button_request_conditioner: directed scenarios plus
// random stimulus against a cycle-level reference model.
module tb_button_request_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] btn_raw = '0;
  logic       step = 1'b0;
  logic       Left, Right, start, restart, pause;
  logic [4:0] held;

  button_request_conditioner #(
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP),
    .CNT_W     (25)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .btn_raw(btn_raw),
    .step   (step),
    .Left   (Left),
    .Right  (Right),
    .start  (start),
    .restart(restart),
    .pause  (pause),
    .held   (held)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [4:0] m_s1, m_s2, m_held, m_hd;
  int         m_run [5];
  logic [1:0] armed;
  int         pt [2];
  int         cyc;
  logic       m_l, m_r, m_st, m_rs, m_pa;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    m_held = '0; m_hd = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    armed = '0;
    pt[0] = 0; pt[1] = 0;
    cyc = 0;
    m_l = 0; m_r = 0; m_st = 0;
    m_rs = 0; m_pa = 0;
  endtask

  function automatic logic [4:0] mpress();
    return m_held & ~m_hd;
  endfunction

  task automatic model_edge(input logic [4:0] raw,
                            input logic stp);
    logic [4:0] p, nh;
    logic [1:0] rep;
    logic       evl, evr, nl, nr;
    int         age;
    p = mpress();
    for (int d = 0; d < 2; d++) begin
      age = cyc - pt[d];
      rep[d] = armed[d] && m_held[d] && age >= RD &&
               ((age - RD) % RP) == 0;
    end
    evl = p[0] | rep[0];
    evr = p[1] | rep[1];
    nl = evl ? 1'b1 : (evr || p[3] || stp) ? 1'b0 : m_l;
    nr = (evr && !evl) ? 1'b1 :
         (evl || p[3] || stp) ? 1'b0 : m_r;
    m_l = nl;
    m_r = nr;
    m_st = p[2] ? 1'b1 : stp ? 1'b0 : m_st;
    m_rs = p[3] ? 1'b1 : stp ? 1'b0 : m_rs;
    m_pa = p[3] ? 1'b0 : p[4] ? ~m_pa : m_pa;
    for (int d = 0; d < 2; d++) begin
      if (p[d]) begin
        armed[d] = 1'b1;
        pt[d] = cyc;
      end else if (!m_held[d]) begin
        armed[d] = 1'b0;
      end
    end
    nh = m_held;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_held[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          nh[i] = ~m_held[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_hd = m_held;
    m_held = nh;
    m_s2 = m_s1;
    m_s1 = raw;
    cyc++;
  endtask

  function automatic logic [9:0] dvec();
    return {held, pause, restart, start, Right, Left};
  endfunction

  function automatic logic [9:0] mvec();
    return {m_held, m_pa, m_rs, m_st, m_r, m_l};
  endfunction

  task automatic tick(input logic [4:0] raw,
                      input logic stp);
    @(negedge CLK);
    btn_raw = raw;
    step = stp;
    @(posedge CLK);
    model_edge(raw, stp);
    #1;
    chk("out", dvec(), mvec());
  endtask

  task automatic press_pulse(input logic [4:0] b);
    repeat (8) tick(b, 1'b0);
    repeat (10) tick(5'b0, 1'b0);
  endtask

  int exp_off [5] = '{0, 20, 28, 36, 44};

  initial begin
    int         first, got;
    int         offs [$];
    logic       r, prev, lseen, prev_r;
    logic [4:0] p, cur;
    logic [9:0] acc;

    model_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst", dvec(), 10'd0);
    RST_N = 1'b1;

    // Bounce on left, then a clean rise
    first = -1;
    for (int k = 0; k < 45; k++) begin
      r = (k >= 30) ? 1'b1 : ((k / 2) % 2 == 1);
      tick({4'b0, r}, 1'b0);
      if (Left && first < 0) first = k;
    end
    chk("bounce_rise", first, 36);
    repeat (3) tick(5'b00001, 1'b0);
    chk("bounce_hold", Left, 1'b1);
    tick(5'b00001, 1'b1);
    chk("bounce_step", Left, 1'b0);
    repeat (12) tick(5'b0, 1'b0);

    // Auto-repeat on right with step on every pending cycle
    prev = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick(k < 50 ? 5'b00010 : 5'b0, m_r);
      if (Right && !prev) offs.push_back(k);
      prev = Right;
    end
    chk("rpt_count", offs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < offs.size()) ? offs[i] - offs[0] : -1;
      chk($sformatf("rpt_off%0d", i), got, exp_off[i]);
    end

    // Step colliding with the start set
    for (int k = 0; k < 12; k++) begin
      p = mpress();
      tick(5'b00100, p[2]);
    end
    chk("coll_start", start, 1'b1);
    tick(5'b0, 1'b1);
    chk("coll_step", start, 1'b0);
    repeat (10) tick(5'b0, 1'b0);

    // Left press over a pending right
    repeat (8) tick(5'b00010, 1'b0);
    repeat (10) tick(5'b0, 1'b0);
    chk("excl_rpend", Right, 1'b1);
    lseen = 1'b0;
    prev_r = Right;
    for (int k = 0; k < 10; k++) begin
      tick(5'b00001, 1'b0);
      if (Left && !lseen) begin
        lseen = 1'b1;
        chk("excl_prev_r", prev_r, 1'b1);
        chk("excl_r", Right, 1'b0);
      end
      prev_r = Right;
    end
    chk("excl_seen", lseen, 1'b1);
    tick(5'b0, 1'b1);
    repeat (10) tick(5'b0, 1'b0);

    // Pause toggling and restart override
    press_pulse(5'b10000);
    chk("pause_1", pause, 1'b1);
    press_pulse(5'b10000);
    chk("pause_0", pause, 1'b0);
    press_pulse(5'b10000);
    chk("pause_2", pause, 1'b1);
    press_pulse(5'b11000);
    chk("prs_pause", pause, 1'b0);
    chk("prs_restart", restart, 1'b1);
    tick(5'b0, 1'b1);
    chk("restart_clr", restart, 1'b0);

    // Short glitch on start
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      tick(k < 3 ? 5'b00100 : 5'b0, 1'b0);
      acc = acc | {8'b0, held[2], start};
    end
    chk("glitch", acc, 10'd0);

    // Random stimulus
    cur = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, b < 2 ? 39 : 11) == 0)
          cur[b] = ~cur[b];
      end
      tick(cur, $urandom_range(0, 3) == 0);
    end
    tick(5'b0, 1'b1);
    repeat (15) tick(5'b0, 1'b0);

    // Reset in the middle of a repeating hold
    if (!m_pa) press_pulse(5'b10000);
    repeat (40) tick(5'b00001, 1'b0);
    chk("pre_pause", pause, 1'b1);
    chk("pre_left", Left, 1'b1);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    btn_raw = '0;
    #1;
    chk("rst_async", dvec(), 10'd0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    acc = '0;
    for (int k = 0; k < 50; k++) begin
      tick(5'b0, 1'b0);
      acc = acc | dvec();
    end
    chk("post_rst", acc, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
